room_cmd_rx: RTL and testbench



---
 rtl/room_cmd_rx.sv | 119 +++++++++++
 tb/tb_room_cmd_rx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/room_cmd_rx.sv
// rtl/room_cmd_rx.sv - 8N1 UART command receiver driving room lock control pulses
module room_cmd_rx #(
    parameter int         CLK_HZ       = 50_000_000,
    parameter int         BAUD         = 115200,
    parameter int         CLKS_PER_BIT = CLK_HZ / BAUD,
    parameter logic [7:0] CMD_AVAIL    = 8'h41,
    parameter logic [7:0] CMD_UNAVAIL  = 8'h55,
    parameter logic [7:0] CMD_UNLOCK   = 8'h4F
) (
    input  logic       FPGA_CLK1_50,
    input  logic       reset,
    input  logic       rx,
    output logic       available,
    output logic       unavailable,
    output logic       unlock_signal,
    output logic       room_available,
    output logic       frame_err,
    output logic [7:0] last_byte
);

    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          rx_meta;
    logic          rxs;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          cnt_clr;
    logic          shift_en;
    logic          byte_done;
    logic          frame_bad;

    always_comb begin
        state_nx  = state;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        byte_done = 1'b0;
        frame_bad = 1'b0;
        case (state)
            WAIT_IDLE: if (rxs) state_nx = IDLE;
            IDLE:      if (!rxs) state_nx = START;
            START: begin
                // Mid-start sample rejects glitches shorter than half a bit.
                if (cnt == HALF_M1) state_nx = rxs ? IDLE : DATA;
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    shift_en = 1'b1;
                    cnt_clr  = 1'b1;
                    if (bit_idx == 3'd7) state_nx = STOP;
                end
            end
            STOP: begin
                if (cnt == FULL_M1) begin
                    if (rxs) begin
                        byte_done = 1'b1;
                        state_nx  = IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_nx  = WAIT_IDLE;
                    end
                end
            end
            default: state_nx = WAIT_IDLE;
        endcase
        if (state_nx != state) cnt_clr = 1'b1;
    end

    always_ff @(posedge FPGA_CLK1_50) begin
        if (reset) begin
            rx_meta        <= 1'b1;
            rxs            <= 1'b1;
            state          <= WAIT_IDLE;
            cnt            <= '0;
            bit_idx        <= 3'd0;
            shreg          <= 8'h00;
            available      <= 1'b0;
            unavailable    <= 1'b0;
            unlock_signal  <= 1'b0;
            room_available <= 1'b0;
            frame_err      <= 1'b0;
            last_byte      <= 8'h00;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            state   <= state_nx;
            cnt     <= cnt_clr ? '0 : cnt + CW'(1);

            if (state_nx != state) bit_idx <= 3'd0;
            else if (shift_en)     bit_idx <= bit_idx + 3'd1;

            if (shift_en) shreg <= {rxs, shreg[7:1]};

            available     <= byte_done && (shreg == CMD_AVAIL);
            unavailable   <= byte_done && (shreg == CMD_UNAVAIL);
            unlock_signal <= byte_done && (shreg == CMD_UNLOCK);
            frame_err     <= frame_bad;

            if (byte_done) begin
                last_byte <= shreg;
                if (shreg == CMD_AVAIL)   room_available <= 1'b1;
                if (shreg == CMD_UNAVAIL) room_available <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_room_cmd_rx.sv
// tb/tb_room_cmd_rx.sv - scoreboard bench for room_cmd_rx
module tb_room_cmd_rx;

    localparam int CPB = 256;
    localparam int LAT = 3 + CPB / 2 + 9 * CPB;

    localparam logic [3:0] K_NONE = 4'b0000;
    localparam logic [3:0] K_AV   = 4'b0001;
    localparam logic [3:0] K_UA   = 4'b0010;
    localparam logic [3:0] K_UL   = 4'b0100;
    localparam logic [3:0] K_FE   = 4'b1000;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       available;
    logic       unavailable;
    logic       unlock_signal;
    logic       room_available;
    logic       frame_err;
    logic [7:0] last_byte;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [3:0] kind;
        int         cyc;
        logic [7:0] lb;
        logic       ra;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    logic [3:0] mon_act;

    room_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
        .FPGA_CLK1_50  (clk),
        .reset         (reset),
        .rx            (rx),
        .available     (available),
        .unavailable   (unavailable),
        .unlock_signal (unlock_signal),
        .room_available(room_available),
        .frame_err     (frame_err),
        .last_byte     (last_byte)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        mon_act = {frame_err, unlock_signal, unavailable, available};
        if (mon_act != 4'b0000) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse got=%b cyc=%0d lb=%h", mon_act, cyc, last_byte);
            end else begin
                mon_e = q.pop_front();
                if (mon_act !== mon_e.kind || cyc != mon_e.cyc ||
                    last_byte !== mon_e.lb || room_available !== mon_e.ra) begin
                    errors++;
                    $display("FAIL pulse got kind=%b cyc=%0d lb=%h ra=%b exp kind=%b cyc=%0d lb=%h ra=%b",
                             mon_act, cyc, last_byte, room_available,
                             mon_e.kind, mon_e.cyc, mon_e.lb, mon_e.ra);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {23'd0, available, unavailable, unlock_signal, room_available,
                   frame_err, last_byte}, 32'd0);
    endtask

    // Entered on a falling edge; leaves on the falling edge where the next frame may start.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic [3:0] kind,
                             input logic [7:0] lb, input logic ra);
        exp_t e;
        rx = 1'b0;
        if (kind != K_NONE) begin
            e.kind = kind;
            e.cyc  = cyc + LAT;
            e.lb   = lb;
            e.ra   = ra;
            q.push_back(e);
        end
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    initial begin
        logic [7:0] b4f;
        b4f   = 8'h4F;
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_state");
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("post_reset_state");
        idle_bits(2);

        // 1: available
        send_byte(8'h41, 1'b1, K_AV, 8'h41, 1'b1);
        idle_bits(2);
        chk("t1_last_byte", {24'd0, last_byte}, 32'h41);
        chk("t1_room_avail", {31'd0, room_available}, 32'd1);

        // 2: back-to-back unlock then unavailable
        send_byte(8'h4F, 1'b1, K_UL, 8'h4F, 1'b1);
        send_byte(8'h55, 1'b1, K_UA, 8'h55, 1'b0);
        idle_bits(2);
        chk("t2_room_avail", {31'd0, room_available}, 32'd0);
        chk("t2_last_byte", {24'd0, last_byte}, 32'h55);

        // 3: framing error, break, recovery
        send_byte(8'h41, 1'b0, K_FE, 8'h55, 1'b0);
        rx = 1'b0;
        repeat (20 * CPB) @(negedge clk);
        chk("t3_last_byte_kept", {24'd0, last_byte}, 32'h55);
        idle_bits(2);
        send_byte(8'h41, 1'b1, K_AV, 8'h41, 1'b1);
        idle_bits(2);

        // 4: short low glitch is ignored
        rx = 1'b0;
        repeat (100) @(negedge clk);
        idle_bits(12);
        chk("t4_last_byte_kept", {24'd0, last_byte}, 32'h41);
        send_byte(8'h4F, 1'b1, K_UL, 8'h4F, 1'b1);
        idle_bits(2);

        // 5: reset midway through data bits aborts the frame
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b4f[i];
            repeat (CPB) @(negedge clk);
        end
        reset = 1'b1;
        rx    = 1'b1;
        @(negedge clk);
        chk_all_zero("t5_during_reset");
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("t5_after_reset");
        idle_bits(12);
        chk_all_zero("t5_aborted_frame_silent");
        send_byte(8'h4F, 1'b1, K_UL, 8'h4F, 1'b0);
        idle_bits(2);

        // 6: non-command byte
        send_byte(8'h5A, 1'b1, K_NONE, 8'h5A, 1'b0);
        idle_bits(2);
        chk("t6_last_byte", {24'd0, last_byte}, 32'h5A);
        chk("t6_room_avail", {31'd0, room_available}, 32'd0);

        chk("pending_expected_pulses", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
